bcd_counter_array: RTL and testbench
====================================

Name: bcd_counter_array

Overview:
- Parametrised multi-digit BCD counter: NUM_DIGITS cascaded 4-bit BCD digits with a ripple-free carry/borrow chain, up/down counting, synchronous load with BCD validation, synchronous clear, and selectable wrap or saturate mode.
- Successor to the per-digit free-running BCD register array; feeds 7-segment display drivers and event tallies in the week-3 datapath.
- Provides a terminal-count strobe and a sticky overflow flag for cascading and monitoring.

Parameters:
- NUM_DIGITS, 8, number of BCD digits; legal range 1..16.
- SATURATE, 0, 0 = wrap at terminal value; 1 = hold at terminal value.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- en  input  1  count enable, one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear to zero
- load  input  1  synchronous load of load_val
- load_val  input  4*NUM_DIGITS  packed BCD load value; digit 0 in bits [3:0]
- ovf_clr  input  1  clears sticky overflow flag
- count  output  4*NUM_DIGITS  packed BCD count; digit 0 in bits [3:0]; registered
- tc  output  1  terminal count; combinational
- ovf  output  1  sticky overflow/underflow flag; registered
- load_err  output  1  one-cycle pulse when a load is rejected; registered

Behaviour:
- Reset (rstn low, asynchronous):
  - count = 0, ovf = 0, load_err = 0 immediately, independent of clk.
  - Release is synchronous to the next rising edge; the first update occurs on the first edge with rstn high.
- Priority per edge: clr > load > en. Lower-priority requests in the same cycle are ignored.
- clr:
  - count <= 0; load_err <= 0.
  - ovf is unaffected by clr; only reset or ovf_clr clears it.
- load, validation:
  - If every digit of load_val is <= 9: count <= load_val, load_err <= 0.
  - If any digit is > 9: count holds, load_err <= 1 for exactly one cycle.
  - No partial load is permitted.
- Count up (en=1, up=1):
  - Digit i increments when all lower digits equal 9; a digit at 9 that increments becomes 0.
  - Latency is one cycle; the full result appears on the next edge.
- Count down (en=1, up=0):
  - Digit i decrements when all lower digits equal 0; a digit at 0 that decrements becomes 9.
- Terminal value:
  - Up direction: all digits 9 (e.g. 99999999).
  - Down direction: all digits 0.
- tc = en & ~clr & ~load & (count == terminal value for the current direction).
- At terminal with en=1 (and no clr/load):
  - SATURATE=0: count wraps (all-9 -> 0 up; 0 -> all-9 down), and ovf <= 1.
  - SATURATE=1: count holds, and ovf <= 1.
- ovf:
  - Sticky; cleared by ovf_clr on an edge.
  - If ovf_clr and a new overflow occur in the same cycle, set wins (ovf = 1).
- en=0 with no clr/load: count holds, tc = 0.
- Direction change takes effect on the same edge; no pipeline state.
- Invalid digits cannot arise internally. The counter never produces a digit > 9 from any legal operation.
- Width rule: no binary addition across digits; each digit is an independent 4-bit BCD step gated by the lower-digit all-9/all-0 condition.

Test Plan:
- Reset, NUM_DIGITS=4: assert rstn=0 mid-count at 0x0457 -> count=0x0000, ovf=0, load_err=0 before the next edge. Release, en=1, up=1 for 12 cycles -> count=0x0012.
- Carry chain: load 0x0999, en=1, up=1 for one cycle -> 0x1000, tc=0. Load 0x9998, two up steps -> 0x9999 with tc=1, then 0x0000 with ovf=1 (SATURATE=0).
- Borrow and underflow: load 0x1000, one down step -> 0x0999. Load 0x0000, down with en=1 -> tc=1, next count=0x9999, ovf=1. Pulse ovf_clr -> ovf=0.
- Saturate, SATURATE=1: load 0x9999, up for 3 cycles -> count stays 0x9999, tc=1 each cycle, ovf=1. Switch up=0 -> 0x9998.
- Load validation: load_val=0x12A4 -> count unchanged, load_err=1 for exactly one cycle. load_val=0x1234 -> count=0x1234, load_err=0.
- Priority:
  - clr, load and en together -> count=0x0000.
  - load and en together with load_val=0x0050 -> count=0x0050, not 0x0051.
  - ovf_clr together with a wrap -> ovf remains 1.

Source files
------------

// File: rtl/bcd_counter_array.sv
// Multi-digit BCD up/down counter with validated load, clear, wrap/saturate terminal handling.
// Latency: one cycle from request to count/ovf/load_err; tc is combinational from the current count and controls.
// No backpressure: a request is accepted on every edge, resolved by clr > load > en priority.
module bcd_counter_array #(
    parameter int NUM_DIGITS = 8,
    parameter int SATURATE   = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      up,
    input  logic                      clr,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    input  logic                      ovf_clr,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic                      tc,
    output logic                      ovf,
    output logic                      load_err
);

    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0] step_val;
    logic         load_ok;
    logic         at_term;
    logic         hold_sat;
    logic         all9;
    logic         all0;
    logic [3:0]   dig;

    // Per-digit BCD step gated by "every lower digit is 9 (up) / 0 (down)";
    // no binary carry ever crosses a digit boundary. Also validates load_val.
    always_comb begin
        step_val = '0;
        load_ok  = 1'b1;
        all9     = 1'b1;
        all0     = 1'b1;
        dig      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count[4*i +: 4];
            if (up) begin
                if (all9) begin
                    step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                end else begin
                    step_val[4*i +: 4] = dig;
                end
            end else begin
                if (all0) begin
                    step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                end else begin
                    step_val[4*i +: 4] = dig;
                end
            end
            all9 = all9 & (dig == 4'd9);
            all0 = all0 & (dig == 4'd0);
            if (load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Terminal value depends on direction: all nines counting up, all zeros counting down.
    assign at_term  = up ? all9 : all0;
    assign tc       = en & ~clr & ~load & at_term;
    // In saturate mode a step from the terminal value is suppressed; in wrap mode the
    // digit step above already rolls over to the opposite extreme.
    assign hold_sat = (SATURATE != 0) && at_term;

    // Count register and one-cycle load rejection pulse, clr > load > en.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count    <= '0;
            load_err <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            if (load_ok) begin
                count <= load_val;
            end
            load_err <= ~load_ok;
        end else begin
            load_err <= 1'b0;
            if (en && !hold_sat) begin
                count <= step_val;
            end
        end
    end

    // Sticky overflow: a new terminal event outranks ovf_clr in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (tc) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_counter_array.sv
// Bench for bcd_counter_array: wrap and saturate instances (4 digits) against an integer reference model.
// Latency: checks tc mid-cycle and registered outputs 1 time unit after each rising edge.
// No backpressure: one stimulus vector per clock.
module tb_bcd_counter_array;

    localparam int ND   = 4;
    localparam int MAXV = 9999;

    logic          clk;
    logic          rstn;
    logic          en;
    logic          up;
    logic          clr;
    logic          load;
    logic [15:0]   load_val;
    logic          ovf_clr;

    logic [15:0]   cnt_w, cnt_s;
    logic          tc_w, tc_s, ovf_w, ovf_s, lerr_w, lerr_s;

    int n_cmp;
    int n_bad;

    // reference state, index 0 = wrap instance, 1 = saturate instance
    int mv[2];
    bit mo[2];
    bit ml[2];

    bcd_counter_array #(.NUM_DIGITS(ND), .SATURATE(0)) dut_w (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
        .count(cnt_w), .tc(tc_w), .ovf(ovf_w), .load_err(lerr_w)
    );

    bcd_counter_array #(.NUM_DIGITS(ND), .SATURATE(1)) dut_s (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
        .count(cnt_s), .tc(tc_s), .ovf(ovf_s), .load_err(lerr_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_legal(input logic [15:0] b);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (int'(b[4*i +: 4]) > 9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int v;
        int p;
        v = 0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            v = v + int'(b[4*i +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0;
            mo[k] = 1'b0;
            ml[k] = 1'b0;
        end
    endtask

    // One clock: drive, check tc mid-cycle, advance model, check registered outputs.
    task automatic cyc(input bit e, input bit u, input bit c, input bit l,
                       input logic [15:0] lv, input bit oc);
        bit term;
        bit tce[2];
        en = e; up = u; clr = c; load = l; load_val = lv; ovf_clr = oc;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            term   = u ? (mv[k] == MAXV) : (mv[k] == 0);
            tce[k] = e && !c && !l && term;
        end
        chk("tc_wrap", {31'd0, tc_w}, {31'd0, tce[0]});
        chk("tc_sat",  {31'd0, tc_s}, {31'd0, tce[1]});
        for (int k = 0; k < 2; k++) begin
            if (c) begin
                mv[k] = 0;
                ml[k] = 1'b0;
            end else if (l) begin
                if (bcd_legal(lv)) begin
                    mv[k] = from_bcd(lv);
                    ml[k] = 1'b0;
                end else begin
                    ml[k] = 1'b1;
                end
            end else begin
                ml[k] = 1'b0;
                if (e) begin
                    if (tce[k]) begin
                        if (k == 0) mv[k] = u ? 0 : MAXV;
                    end else begin
                        mv[k] = u ? mv[k] + 1 : mv[k] - 1;
                    end
                end
            end
            if (oc) mo[k] = 1'b0;
            if (tce[k]) mo[k] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("count_wrap", {16'd0, cnt_w}, {16'd0, to_bcd(mv[0])});
        chk("count_sat",  {16'd0, cnt_s}, {16'd0, to_bcd(mv[1])});
        chk("ovf_wrap",   {31'd0, ovf_w}, {31'd0, mo[0]});
        chk("ovf_sat",    {31'd0, ovf_s}, {31'd0, mo[1]});
        chk("lerr_wrap",  {31'd0, lerr_w}, {31'd0, ml[0]});
        chk("lerr_sat",   {31'd0, lerr_s}, {31'd0, ml[1]});
    endtask

    task automatic ld(input logic [15:0] v);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, v, 1'b0);
    endtask

    initial begin
        logic [15:0] lv;
        int          r;
        n_cmp = 0;
        n_bad = 0;
        rstn = 1'b0;
        en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {16'd0, cnt_w}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf_w}, 32'd0);
        chk("rst_lerr",  {31'd0, lerr_s}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // carry chain and wrap
        ld(16'h0999);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("carry_0999", {16'd0, cnt_w}, 32'h1000);
        ld(16'h9998);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("wrap_up", {16'd0, cnt_w}, 32'h0000);
        chk("wrap_ovf", {31'd0, ovf_w}, 32'd1);

        // borrow and underflow
        ld(16'h1000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("borrow_1000", {16'd0, cnt_w}, 32'h0999);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        ld(16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("underflow", {16'd0, cnt_w}, 32'h9999);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("ovf_cleared", {31'd0, ovf_w}, 32'd0);

        // saturation
        ld(16'h9999);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("sat_hold", {16'd0, cnt_s}, 32'h9999);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("sat_down", {16'd0, cnt_s}, 32'h9998);

        // load validation
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h12A4, 1'b0);
        chk("bad_load_err", {31'd0, lerr_w}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        ld(16'h1234);
        chk("good_load", {16'd0, cnt_w}, 32'h1234);

        // priority
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h5678, 1'b0);
        chk("clr_wins", {16'd0, cnt_w}, 32'h0000);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0050, 1'b0);
        chk("load_over_en", {16'd0, cnt_w}, 32'h0050);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        ld(16'h9999);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("set_beats_clr", {31'd0, ovf_w}, 32'd1);

        // asynchronous reset mid-count
        ld(16'h0457);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_count", {16'd0, cnt_w}, 32'd0);
        chk("arst_ovf",   {31'd0, ovf_w}, 32'd0);
        chk("arst_lerr",  {31'd0, lerr_w}, 32'd0);
        model_reset();
        en = 1'b0; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        repeat (12) cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("post_rst_12", {16'd0, cnt_w}, 32'h0012);

        // randomized traffic, biased toward the terminal values
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                lv = 16'($urandom);
            end else if (r < 6) begin
                case ($urandom_range(0, 3))
                    0: lv = to_bcd(0);
                    1: lv = to_bcd(1);
                    2: lv = to_bcd(MAXV - 1);
                    default: lv = to_bcd(MAXV);
                endcase
            end else begin
                lv = to_bcd(int'($urandom_range(0, MAXV)));
            end
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                lv, $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
